// File: rtl/hazard_mem_ctrl.sv
// Hazard and data-memory wait controller for the 5-stage pipelined MIPS datapath.
// Produces forwarding selects, load-use/branch stalls, and sequences variable-latency memory.
module hazard_mem_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemToRegE,
   input  logic             MemToRegM,
   input  logic             MemWriteM,
   input  logic             BranchD,
   input  logic             MemAckM,
   output logic             MemReqM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushE,
   output logic             FlushW,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] MemWaitCycles
);

   localparam int unsigned WC_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] mem_wait_cycles_q, mem_wait_cycles_d;

   logic       lwstall, brstall, hazard_stall;
   logic       mem_acc, mem_req, mem_stall;
   logic       stall_f;
   logic [1:0] fwd_ae, fwd_be;
   logic       fwd_ad, fwd_bd;

   // Register 0 is hard-wired to zero, so it never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] dst_m, input logic we_m,
                                          input logic [4:0] dst_w, input logic we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (src != 5'd0 && we_m && src == dst_m) begin
         sel = 2'b10;
      end else if (src != 5'd0 && we_w && src == dst_w) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_ae = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      fwd_be = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
      fwd_ad = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
      fwd_bd = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

      lwstall = MemToRegE && ((RtE == RsD) || (RtE == RtD));
      brstall = BranchD &&
                ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                 (MemToRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
      hazard_stall = lwstall || brstall;

      mem_acc   = MemToRegM || MemWriteM;
      mem_req   = mem_acc && (state_q != ERR);
      mem_stall = (mem_req && !MemAckM) || (state_q == ERR);
      stall_f   = mem_stall || hazard_stall;
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      unique case (state_q)
         RUN: begin
            if (mem_req && !MemAckM) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (MemAckM) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
               state_d       = ERR;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end
         end
         ERR: begin
            mem_timeout_d = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cycles_d    = stall_cycles_q;
      mem_wait_cycles_d = mem_wait_cycles_q;
      if (stall_f && stall_cycles_q != '1) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (mem_stall && mem_wait_cycles_q != '1) begin
         mem_wait_cycles_d = mem_wait_cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q           <= RUN;
         wait_cnt_q        <= '0;
         mem_timeout_q     <= 1'b0;
         stall_cycles_q    <= '0;
         mem_wait_cycles_q <= '0;
      end else begin
         state_q           <= state_d;
         wait_cnt_q        <= wait_cnt_d;
         mem_timeout_q     <= mem_timeout_d;
         stall_cycles_q    <= stall_cycles_d;
         mem_wait_cycles_q <= mem_wait_cycles_d;
      end
   end

   // Memory freeze wins over hazard stalls: the D->E register holds instead of flushing.
   always_comb begin
      MemReqM   = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (RST_n) begin
         MemReqM   = mem_req;
         ForwardAE = fwd_ae;
         ForwardBE = fwd_be;
         ForwardAD = fwd_ad;
         ForwardBD = fwd_bd;
         if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = hazard_stall;
            StallD = hazard_stall;
            FlushE = hazard_stall;
         end
      end
   end

   assign MemTimeout    = mem_timeout_q;
   assign StallCycles   = stall_cycles_q;
   assign MemWaitCycles = mem_wait_cycles_q;

endmodule
